// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush sequencer for the 5-stage 16-bit pipeline.
// Tracks destination info for EX/MEM, issues hold/bubble/flush strobes and registered forward selects.
module pipe_hazard_ctrl #(
  parameter int RESET_HOLD = 2,
  parameter bit ZERO_REG   = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       id_rs,
  input  logic [2:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [2:0]       id_wreg,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             mem_branch_tk,
  input  logic             id_jump,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {HOLD, RUN, LDSTALL} state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] wreg;
    logic       we;
  } dest_t;

  typedef struct packed {
    dest_t dst;
    logic  load;
  } ex_shadow_t;

  localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(RESET_HOLD);
  // With no warm-up requested the pipeline runs from the first cycle after reset.
  localparam state_e RESET_STATE = (RESET_HOLD == 0) ? RUN : HOLD;

  state_e          state_q;
  logic [HW-1:0]   hold_cnt_q;
  ex_shadow_t      ex_q, ex_d;
  dest_t           mem_q, mem_d;
  logic [1:0]      fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_q;

  logic running, branch, load_use;
  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;

  function automatic logic hit(dest_t s, logic [2:0] r, logic used);
    return used && s.valid && s.we && (s.wreg == r) && !(ZERO_REG && (r == 3'd0));
  endfunction

  // Newest producer wins; a load still in EX cannot forward and is handled by the stall.
  function automatic logic [1:0] fwd_sel(logic ex_hit, logic ex_load, logic mem_hit);
    if (ex_hit && !ex_load) return 2'b01;
    else if (mem_hit)       return 2'b10;
    else                    return 2'b00;
  endfunction

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    running     = (state_q != HOLD);
    ex_hit_rs   = hit(ex_q.dst, id_rs, id_uses_rs);
    ex_hit_rt   = hit(ex_q.dst, id_rt, id_uses_rt);
    mem_hit_rs  = hit(mem_q, id_rs, id_uses_rs);
    mem_hit_rt  = hit(mem_q, id_rt, id_uses_rt);
    load_use    = (state_q == RUN) && ex_q.load && (ex_hit_rs || ex_hit_rt);
    branch      = running && mem_branch_tk;

    pc_hold     = !running || (load_use && !branch);
    ifid_hold   = pc_hold;
    idex_bubble = !running || load_use || branch;
    ifid_flush  = branch || (running && id_jump && !load_use);
    exmem_flush = branch;

    ex_d        = '0;
    if (!idex_bubble) ex_d = '{dst: '{valid: 1'b1, wreg: id_wreg, we: id_regwrite}, load: id_memread};
    mem_d       = exmem_flush ? '0 : ex_q.dst;

    fwd_a_d     = 2'b00;
    fwd_b_d     = 2'b00;
    if (!idex_bubble) begin
      fwd_a_d = fwd_sel(ex_hit_rs, ex_q.load, mem_hit_rs);
      fwd_b_d = fwd_sel(ex_hit_rt, ex_q.load, mem_hit_rt);
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RESET_STATE;
      hold_cnt_q <= HOLD_INIT;
      ex_q       <= '0;
      mem_q      <= '0;
      fwd_a_q    <= 2'b00;
      fwd_b_q    <= 2'b00;
      stall_q    <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      if (running && pc_hold && (stall_q != '1)) stall_q <= stall_q + 1'b1;

      unique case (state_q)
        HOLD: begin
          hold_cnt_q <= hold_cnt_q - 1'b1;
          if (hold_cnt_q <= HW'(1)) state_q <= RUN;
        end
        RUN:     if (!branch && load_use) state_q <= LDSTALL;
        LDSTALL: state_q <= RUN;
        default: state_q <= HOLD;
      endcase
    end
  end

  assign fwd_a        = fwd_a_q;
  assign fwd_b        = fwd_b_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random traffic
// compared against an in-flight instruction model.
module tb_pipe_hazard_ctrl;

  localparam int RESET_HOLD = 2;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic [2:0]       id_rs, id_rt, id_wreg;
  logic             id_uses_rs, id_uses_rt, id_regwrite, id_memread;
  logic             mem_branch_tk, id_jump;
  logic             pc_hold, ifid_hold, ifid_flush, idex_bubble, exmem_flush;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cycles;

  pipe_hazard_ctrl #(.RESET_HOLD(RESET_HOLD), .ZERO_REG(1'b1), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_wreg(id_wreg), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .mem_branch_tk(mem_branch_tk), .id_jump(id_jump),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .exmem_flush(exmem_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit       rst;
    bit [2:0] rs, rt, wreg;
    bit       urs, urt, we, ld, br, jmp;
  } stim_t;

  // An instruction in flight: pipe[0] sits in EX, pipe[1] in MEM.
  typedef struct {
    bit v;
    int w;
    bit we;
    bit ld;
  } instr_t;

  int     n_checks = 0;
  int     n_errors = 0;
  bit     model_ok = 0;
  int     hold_left;
  instr_t pipe [2];
  int     m_fwd_a, m_fwd_b, m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic stim_t nop();
    stim_t s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t alu(bit [2:0] w, bit [2:0] rs, bit [2:0] rt);
    stim_t s = nop();
    s.wreg = w; s.we = 1; s.rs = rs; s.rt = rt; s.urs = 1; s.urt = 1;
    return s;
  endfunction

  function automatic stim_t load(bit [2:0] w, bit [2:0] rs);
    stim_t s = alu(w, rs, 3'd0);
    s.urt = 0; s.ld = 1;
    return s;
  endfunction

  function automatic bit reads(instr_t e, int r, bit used);
    return used && e.v && e.we && (e.w == r) && (r != 0);
  endfunction

  function automatic int pick(int r, bit used);
    if (reads(pipe[0], r, used) && !pipe[0].ld) return 1;
    if (reads(pipe[1], r, used))                return 2;
    return 0;
  endfunction

  // Drive one cycle of ID-stage inputs, compare every output, then advance the model.
  task automatic step(input stim_t s);
    bit running, lu, br, e_pc, e_bub, e_iff, e_exf;
    instr_t bubble;
    @(negedge clock);
    reset = s.rst; id_rs = s.rs; id_rt = s.rt; id_uses_rs = s.urs; id_uses_rt = s.urt;
    id_wreg = s.wreg; id_regwrite = s.we; id_memread = s.ld;
    mem_branch_tk = s.br; id_jump = s.jmp;
    #1;
    running = (hold_left == 0);
    lu      = running && pipe[0].ld && (reads(pipe[0], s.rs, s.urs) || reads(pipe[0], s.rt, s.urt));
    br      = running && s.br;
    e_pc    = !running || (lu && !br);
    e_bub   = !running || lu || br;
    e_iff   = running && (br || (s.jmp && !lu));
    e_exf   = br;
    if (model_ok) begin
      check("pc_hold", pc_hold, e_pc);
      check("ifid_hold", ifid_hold, e_pc);
      check("ifid_flush", ifid_flush, e_iff);
      check("idex_bubble", idex_bubble, e_bub);
      check("exmem_flush", exmem_flush, e_exf);
      check("fwd_a", fwd_a, m_fwd_a);
      check("fwd_b", fwd_b, m_fwd_b);
      check("stall_cycles", stall_cycles, m_cnt);
    end
    bubble = '{v: 0, w: 0, we: 0, ld: 0};
    if (s.rst) begin
      model_ok  = 1;
      hold_left = RESET_HOLD;
      pipe[0]   = bubble;
      pipe[1]   = bubble;
      m_fwd_a   = 0;
      m_fwd_b   = 0;
      m_cnt     = 0;
    end else if (model_ok) begin
      m_fwd_a = e_bub ? 0 : pick(s.rs, s.urs);
      m_fwd_b = e_bub ? 0 : pick(s.rt, s.urt);
      if (running && e_pc && m_cnt < CNT_MAX) m_cnt++;
      pipe[1] = e_exf ? bubble : pipe[0];
      pipe[0] = e_bub ? bubble : '{v: 1, w: s.wreg, we: s.we, ld: s.ld};
      if (hold_left > 0) hold_left--;
    end
  endtask

  initial begin
    stim_t s;
    reset = 1; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_wreg = 0; id_regwrite = 0; id_memread = 0; mem_branch_tk = 0; id_jump = 0;

    // Reset then warm-up hold.
    s = nop(); s.rst = 1;
    step(s);
    step(nop()); check("hold_cycle0", pc_hold, 1);
    step(nop()); check("hold_cycle1", pc_hold, 1);
    step(nop()); check("run_pc_hold", pc_hold, 0);
    check("run_fwd_a", fwd_a, 0);
    check("run_count", stall_cycles, 0);

    // Back-to-back ALU dependency, then one-gap dependency.
    step(alu(3, 1, 1)); step(alu(4, 3, 5)); check("alu_no_stall", pc_hold, 0);
    step(nop()); check("alu_fwd_a_ex", fwd_a, 1); check("alu_fwd_b_none", fwd_b, 0);
    step(alu(3, 1, 1)); step(nop()); step(alu(4, 3, 5)); step(nop());
    check("gap_fwd_a_mem", fwd_a, 2);

    // Load-use: one stall cycle, then forwarding from MEM/WB.
    step(load(2, 1));
    step(alu(6, 1, 2)); check("lu_pc_hold", pc_hold, 1); check("lu_bubble", idex_bubble, 1);
    step(alu(6, 1, 2)); check("lu_release", pc_hold, 0);
    step(nop()); check("lu_fwd_b", fwd_b, 2); check("lu_count", stall_cycles, 1);

    // Branch taken while a load-use would stall.
    step(load(2, 1));
    s = alu(6, 1, 2); s.br = 1;
    step(s);
    check("br_pc_hold", pc_hold, 0); check("br_ifid_flush", ifid_flush, 1);
    check("br_bubble", idex_bubble, 1); check("br_exmem_flush", exmem_flush, 1);
    step(nop()); check("br_after_hold", pc_hold, 0); check("br_count", stall_cycles, 1);

    // Register 0 never creates a hazard.
    step(load(0, 1));
    step(alu(6, 0, 0)); check("r0_no_stall", pc_hold, 0);
    step(nop()); check("r0_fwd_a", fwd_a, 0); check("r0_fwd_b", fwd_b, 0);

    // Reset during the load-use stall cycle.
    step(load(5, 1));
    step(alu(6, 5, 1)); check("ldst_enter", pc_hold, 1);
    s = alu(6, 5, 1); s.rst = 1;
    step(s);
    step(nop()); check("rst_ldst_hold", pc_hold, 1); check("rst_ldst_fwd_a", fwd_a, 0);
    check("rst_ldst_count", stall_cycles, 0);
    step(nop()); step(nop());

    // Jump gives a single-cycle IF/ID flush.
    s = nop(); s.jmp = 1;
    step(s); check("jmp_flush", ifid_flush, 1);
    step(nop()); check("jmp_flush_end", ifid_flush, 0);

    // Saturate the stall counter.
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      step(load(2, 1)); step(alu(6, 1, 2)); step(alu(6, 1, 2));
    end
    step(nop()); check("cnt_saturated", stall_cycles, CNT_MAX);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      s.rst  = ($urandom_range(0, 199) == 0);
      s.rs   = 3'($urandom_range(0, 7));
      s.rt   = 3'($urandom_range(0, 7));
      s.wreg = 3'($urandom_range(0, 7));
      s.urs  = 1'($urandom_range(0, 1));
      s.urt  = 1'($urandom_range(0, 1));
      s.we   = ($urandom_range(0, 3) != 0);
      s.ld   = ($urandom_range(0, 2) == 0);
      s.br   = ($urandom_range(0, 7) == 0);
      s.jmp  = ($urandom_range(0, 7) == 0);
      step(s);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
